// File: rtl/timer_clint.sv
// Multi-hart machine timer: a 64-bit mtime with a prescaler, NUM_HART mtimecmp channels and
// level interrupts. It is reached over a single-cycle valid/ready bus.
module timer_clint #(
  parameter int unsigned NUM_HART  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0020_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                timer_valid,
  input  logic                timer_instr,
  input  logic [31:0]         timer_addr,
  input  logic [31:0]         timer_wdata,
  input  logic [3:0]          timer_wstrb,
  output logic [31:0]         timer_rdata,
  output logic                timer_ready,
  output logic [NUM_HART-1:0] timer_irpt
);

  localparam int unsigned CntW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned WinBytes = 8 * (NUM_HART + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                tick;
  logic [63:0]         mtime_q, mtime_d;
  logic [63:0]         cmp_q [NUM_HART];
  logic [63:0]         cmp_d [NUM_HART];
  logic [NUM_HART-1:0] irpt_q, irpt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q;

  logic [31:0] offset;
  logic        in_win;
  logic [28:0] pair;
  logic        hi_word;
  logic        acc;
  logic        wr;
  logic        unused_offset;

  // Each 8-byte pair is one 64-bit register: cmp channels first, mtime last.
  assign offset        = timer_addr - BASE_ADDR;
  assign in_win        = (timer_addr >= BASE_ADDR) && (offset < 32'(WinBytes));
  assign pair          = offset[31:3];
  assign hi_word       = offset[2];
  assign unused_offset = ^offset[1:0];
  assign acc           = timer_valid && !timer_instr && in_win;
  assign wr            = acc && (timer_wstrb != 4'h0);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    tick    = (cnt_q == CntMax);
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    mtime_d = mtime_q + 64'(tick);
    cmp_d   = cmp_q;
    rdata_d = '0;
    irpt_d  = '0;

    if (acc) begin
      if (pair == 29'(NUM_HART)) begin
        rdata_d = hi_word ? mtime_q[63:32] : mtime_q[31:0];
        // A bus write replaces the whole next value, so a same-cycle tick is dropped.
        if (wr) begin
          if (hi_word) begin
            mtime_d = {merge_bytes(mtime_q[63:32], timer_wdata, timer_wstrb), mtime_q[31:0]};
          end else begin
            mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], timer_wdata, timer_wstrb)};
          end
        end
      end else begin
        for (int unsigned i = 0; i < NUM_HART; i++) begin
          if (pair == 29'(i)) begin
            rdata_d = hi_word ? cmp_q[i][63:32] : cmp_q[i][31:0];
            if (wr) begin
              if (hi_word) begin
                cmp_d[i][63:32] = merge_bytes(cmp_q[i][63:32], timer_wdata, timer_wstrb);
              end else begin
                cmp_d[i][31:0] = merge_bytes(cmp_q[i][31:0], timer_wdata, timer_wstrb);
              end
            end
          end
        end
      end
    end

    // Compare current register contents; the result appears one cycle after they change.
    for (int unsigned i = 0; i < NUM_HART; i++) begin
      irpt_d[i] = (mtime_q >= cmp_q[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      mtime_q <= '0;
      for (int unsigned i = 0; i < NUM_HART; i++) begin
        cmp_q[i] <= '1;
      end
      irpt_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irpt_q  <= irpt_d;
      rdata_q <= rdata_d;
      ready_q <= timer_valid;
    end
  end

  assign timer_rdata = rdata_q;
  assign timer_ready = ready_q;
  assign timer_irpt  = irpt_q;

endmodule

// File: tb/tb_timer_clint.sv
// Bench for timer_clint: a 2-hart prescale-1 instance and a 1-hart prescale-4 instance.
// Expected bus responses are queued when a request is driven and compared when ready returns.
module tb_timer_clint;

  localparam logic [31:0] Base   = 32'h0020_0000;
  localparam logic [31:0] Cmp0Lo = 32'h00;
  localparam logic [31:0] Cmp0Hi = 32'h04;
  localparam logic [31:0] Cmp1Lo = 32'h08;
  localparam logic [31:0] Cmp1Hi = 32'h0C;
  localparam logic [31:0] MtLo   = 32'h10;
  localparam logic [31:0] MtHi   = 32'h14;

  logic        clock = 1'b0;
  logic        reset;
  always #5 clock = ~clock;

  logic        valid, instr, ready;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  irpt;

  logic        valid4, instr4, ready4;
  logic [31:0] addr4, wdata4, rdata4;
  logic [3:0]  wstrb4;
  logic [0:0]  irpt4;

  timer_clint #(.NUM_HART(2), .BASE_ADDR(Base), .PRESCALE(1)) u_dut (
    .clock(clock), .reset(reset), .timer_valid(valid), .timer_instr(instr),
    .timer_addr(addr), .timer_wdata(wdata), .timer_wstrb(wstrb),
    .timer_rdata(rdata), .timer_ready(ready), .timer_irpt(irpt)
  );

  timer_clint #(.NUM_HART(1), .BASE_ADDR(Base), .PRESCALE(4)) u_dut_p4 (
    .clock(clock), .reset(reset), .timer_valid(valid4), .timer_instr(instr4),
    .timer_addr(addr4), .timer_wdata(wdata4), .timer_wstrb(wstrb4),
    .timer_rdata(rdata4), .timer_ready(ready4), .timer_irpt(irpt4)
  );

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp;
  int          n_bad;
  int          cyc;
  logic [63:0] m_base;
  int          m_cyc;

  // Clock edges since reset release; mtime model is m_base plus elapsed edges.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [63:0] exp_mt();
    return m_base + 64'(cyc - m_cyc);
  endfunction

  task automatic wait_to(input int t);
    if (t > cyc) repeat (t - cyc) @(negedge clock);
  endtask

  // Called at a negedge; returns at the negedge where the response is visible.
  task automatic req(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s,
                     input logic f, input logic chk, input logic [31:0] e);
    exp_t x;
    x.chk = chk;
    x.data = e;
    exp_q.push_back(x);
    valid = 1'b1; addr = Base + off; wdata = d; wstrb = s; instr = f;
    @(posedge clock);
    @(negedge clock);
    valid = 1'b0; wstrb = 4'h0; instr = 1'b0;
  endtask

  task automatic req4(input logic [31:0] off, input logic [31:0] e);
    exp_t x;
    x.chk = 1'b1;
    x.data = e;
    exp_q.push_back(x);
    valid4 = 1'b1; addr4 = Base + off; wdata4 = '0; wstrb4 = 4'h0; instr4 = 1'b0;
    @(posedge clock);
    @(negedge clock);
    valid4 = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] offs [6] = '{MtLo, MtHi, Cmp0Lo, Cmp0Hi, Cmp1Lo, Cmp1Hi};
    logic [31:0] exps [6] = '{32'h5, 32'h0, '1, '1, '1, '1};
    exp_t ex;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (ready !== 1'b0 || rdata !== 32'h0 || irpt !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_out: ready=%b rdata=%h irpt=%b, want 0/0/00", ready, rdata, irpt);
    end
    reset = 1'b1;
    m_base = '0;
    m_cyc = 0;
    wait_to(5);
    for (int i = 0; i < 6; i++) begin
      req(offs[i], '0, 4'h0, 1'b0, 1'b1, exps[i]);
      ex = exp_q.pop_front();
      n_cmp++;
      if (ready !== 1'b1 || rdata !== ex.data) begin
        n_bad++;
        $display("FAIL rst_rd%0d: ready=%b rdata=%h, want 1/%h", i, ready, rdata, ex.data);
      end
    end
    n_cmp++;
    if (irpt !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_irpt: irpt=%b, want 00", irpt);
    end
  endtask

  task automatic test_prescale();
    int          at   [4] = '{20, 23, 24, 40};
    logic [31:0] exps [4] = '{32'd5, 32'd5, 32'd6, 32'd10};
    exp_t ex;
    for (int i = 0; i < 4; i++) begin
      wait_to(at[i]);
      req4(32'h8, exps[i]);
      ex = exp_q.pop_front();
      n_cmp++;
      if (ready4 !== 1'b1 || rdata4 !== ex.data) begin
        n_bad++;
        $display("FAIL p4_mt%0d: ready=%b rdata=%h, want 1/%h", i, ready4, rdata4, ex.data);
      end
    end
    req4(32'h4, '1);
    ex = exp_q.pop_front();
    n_cmp++;
    if (ready4 !== 1'b1 || rdata4 !== ex.data || irpt4 !== 1'b0) begin
      n_bad++;
      $display("FAIL p4_cmp: ready=%b rdata=%h irpt=%b, want 1/%h/0", ready4, rdata4, irpt4,
               ex.data);
    end
  endtask

  task automatic test_irq();
    logic [31:0] offs [3] = '{MtLo, Cmp1Lo, Cmp1Hi};
    logic [31:0] data [3] = '{32'h0, 32'h10, 32'h0};
    logic [63:0] mt;
    exp_t ex;
    for (int i = 0; i < 3; i++) begin
      req(offs[i], data[i], 4'hF, 1'b0, 1'b0, '0);
      if (i == 0) begin
        m_base = '0;
        m_cyc = cyc;
      end
      ex = exp_q.pop_front();
      n_cmp++;
      if (ready !== 1'b1) begin
        n_bad++;
        $display("FAIL irq_wr%0d: ready=%b, want 1", i, ready);
      end
    end
    wait_to(m_cyc + 16);
    n_cmp++;
    if (irpt !== 2'b00) begin
      n_bad++;
      $display("FAIL irq_pre: irpt=%b, want 00", irpt);
    end
    @(negedge clock);
    n_cmp++;
    if (irpt !== 2'b10) begin
      n_bad++;
      $display("FAIL irq_set: irpt=%b, want 10", irpt);
    end
    mt = exp_mt();
    req(MtLo, '0, 4'h0, 1'b0, 1'b1, mt[31:0]);
    ex = exp_q.pop_front();
    n_cmp++;
    if (ready !== 1'b1 || rdata !== ex.data) begin
      n_bad++;
      $display("FAIL irq_mt: ready=%b rdata=%h, want 1/%h", ready, rdata, ex.data);
    end
    req(Cmp1Hi, '1, 4'hF, 1'b0, 1'b0, '0);
    ex = exp_q.pop_front();
    n_cmp++;
    if (ready !== 1'b1 || irpt !== 2'b10) begin
      n_bad++;
      $display("FAIL irq_hold: ready=%b irpt=%b, want 1/10", ready, irpt);
    end
    @(negedge clock);
    n_cmp++;
    if (irpt !== 2'b00) begin
      n_bad++;
      $display("FAIL irq_clr: irpt=%b, want 00", irpt);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] mt;
    exp_t ex;
    req(Cmp0Lo, 32'h8, 4'hF, 1'b0, 1'b0, '0);
    ex = exp_q.pop_front();
    req(Cmp0Hi, 32'h0, 4'hF, 1'b0, 1'b0, '0);
    ex = exp_q.pop_front();
    mt = exp_mt();
    req(MtHi, '1, 4'hF, 1'b0, 1'b0, '0);
    ex = exp_q.pop_front();
    m_base = {32'hFFFF_FFFF, mt[31:0]};
    m_cyc = cyc;
    req(MtLo, 32'hFFFF_FFFE, 4'hF, 1'b0, 1'b0, '0);
    ex = exp_q.pop_front();
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_wr: ready=%b, want 1", ready);
    end
    m_base = 64'hFFFF_FFFF_FFFF_FFFE;
    m_cyc = cyc;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (irpt !== 2'b11) begin
      n_bad++;
      $display("FAIL wrap_pre: irpt=%b, want 11", irpt);
    end
    req(MtLo, '0, 4'h0, 1'b0, 1'b1, 32'h0);
    ex = exp_q.pop_front();
    n_cmp++;
    if (ready !== 1'b1 || rdata !== ex.data) begin
      n_bad++;
      $display("FAIL wrap_lo: ready=%b rdata=%h, want 1/%h", ready, rdata, ex.data);
    end
    n_cmp++;
    if (irpt !== 2'b00) begin
      n_bad++;
      $display("FAIL wrap_clr: irpt=%b, want 00", irpt);
    end
    req(MtHi, '0, 4'h0, 1'b0, 1'b1, 32'h0);
    ex = exp_q.pop_front();
    n_cmp++;
    if (ready !== 1'b1 || rdata !== ex.data) begin
      n_bad++;
      $display("FAIL wrap_hi: ready=%b rdata=%h, want 1/%h", ready, rdata, ex.data);
    end
  endtask

  task automatic test_byte_write();
    logic [63:0] mt;
    logic [63:0] w;
    exp_t ex;
    mt = exp_mt();
    w = {mt[63:8], 8'hAB};
    req(MtLo, 32'h5555_55AB, 4'b0001, 1'b0, 1'b0, '0);
    ex = exp_q.pop_front();
    m_base = w;
    m_cyc = cyc;
    req(MtLo, '0, 4'h0, 1'b0, 1'b1, w[31:0]);
    ex = exp_q.pop_front();
    n_cmp++;
    if (ready !== 1'b1 || rdata !== ex.data) begin
      n_bad++;
      $display("FAIL byte_wr: ready=%b rdata=%h, want 1/%h", ready, rdata, ex.data);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] mt;
    exp_t ex;
    for (int i = 0; i < 6; i++) begin
      mt = exp_mt();
      if (i % 2 == 0) req(MtLo, '0, 4'h0, 1'b0, 1'b1, mt[31:0]);
      else            req(Cmp0Lo, '0, 4'h0, 1'b0, 1'b1, 32'h8);
      ex = exp_q.pop_front();
      n_cmp++;
      if (ready !== 1'b1 || rdata !== ex.data) begin
        n_bad++;
        $display("FAIL b2b_%0d: ready=%b rdata=%h, want 1/%h", i, ready, rdata, ex.data);
      end
    end
    @(negedge clock);
    n_cmp++;
    if (ready !== 1'b0 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL b2b_idle: ready=%b rdata=%h, want 0/0", ready, rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] offs [8] = '{Cmp1Lo, Cmp0Lo, 32'h40, 32'hFFFF_FFFC, Cmp0Lo, Cmp0Lo,
                              32'h18, Cmp0Hi};
    logic [31:0] data [8] = '{'0, '0, '0, '0, '0, 32'h0, 32'h0, '0};
    logic [3:0]  strb [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0};
    logic        fch  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] exps [8] = '{'1, '1, '0, '0, '0, '0, '0, '1};
    logic [63:0] mt;
    exp_t ex;
    valid = 1'b1; addr = Base + MtLo; wstrb = 4'h0; instr = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (ready !== 1'b0 || rdata !== 32'h0 || irpt !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_rst: ready=%b rdata=%h irpt=%b, want 0/0/00", ready, rdata, irpt);
    end
    @(negedge clock);
    reset = 1'b1;
    m_base = '0;
    m_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      req(offs[i], data[i], strb[i], fch[i], 1'b1, exps[i]);
      ex = exp_q.pop_front();
      n_cmp++;
      if (ready !== 1'b1 || rdata !== ex.data) begin
        n_bad++;
        $display("FAIL post_rst%0d: ready=%b rdata=%h, want 1/%h", i, ready, rdata, ex.data);
      end
    end
    req(Cmp0Lo, '0, 4'h0, 1'b0, 1'b1, '1);
    ex = exp_q.pop_front();
    n_cmp++;
    if (ready !== 1'b1 || rdata !== ex.data) begin
      n_bad++;
      $display("FAIL fetch_nowr: ready=%b rdata=%h, want 1/%h", ready, rdata, ex.data);
    end
    mt = exp_mt();
    req(MtLo, '0, 4'h0, 1'b0, 1'b1, mt[31:0]);
    ex = exp_q.pop_front();
    n_cmp++;
    if (ready !== 1'b1 || rdata !== ex.data) begin
      n_bad++;
      $display("FAIL post_rst_mt: ready=%b rdata=%h, want 1/%h", ready, rdata, ex.data);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    valid = 1'b0; instr = 1'b0; addr = '0; wdata = '0; wstrb = 4'h0;
    valid4 = 1'b0; instr4 = 1'b0; addr4 = '0; wdata4 = '0; wstrb4 = 4'h0;
    m_base = '0;
    m_cyc = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    test_reset();
    test_prescale();
    test_irq();
    test_wrap();
    test_byte_write();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
